// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: fetch PC, prefetch queue, redirect flush.
// Define FETCH_SEQ_PERF_EN to build the fetch/bubble performance counters.
module fetch_sequencer #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        fault,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_bubbles
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [16:0] LIM = 17'(MEM_SIZE);

  typedef enum logic {
    FETCH,
    HALT
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [15:0]   iq_q [DEPTH];
  logic [15:0]   pq_q [DEPTH];

  logic in_bounds;
  logic deq;
  logic enq;

  assign in_bounds = ({1'b0, pc_q} + 17'd3) < LIM;
  assign out_valid = (cnt_q != '0);
  assign out_instr = iq_q[rd_q];
  assign out_pc    = pq_q[rd_q];
  assign imem_addr = pc_q;
  assign fault     = fault_q;

  // Redirect wins over both queue ports: the head is dropped, not handed over.
  assign deq = out_valid && out_ready && !redirect_valid;
  assign enq = (state_q == FETCH) && !redirect_valid && in_bounds
            && ((cnt_q != FULL) || deq);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = FETCH;
        fault_d = 1'b0;
      end else begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    end else begin
      if (state_q == FETCH && !in_bounds) begin
        state_d = HALT;
        fault_d = 1'b1;
      end
      if (enq) begin
        pc_d = pc_q + 16'd4;
        wr_d = wr_q + PW'(1);
      end
      if (deq) begin
        rd_d = rd_q + PW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        iq_q[i] <= '0;
        pq_q[i] <= '0;
      end
    end else if (enq) begin
      iq_q[wr_q] <= imem_instr;
      pq_q[wr_q] <= pc_q;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] fet_q;
  logic [15:0] bub_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fet_q <= '0;
      bub_q <= '0;
    end else begin
      if (enq && fet_q != 16'hFFFF) fet_q <= fet_q + 16'd1;
      if (!out_valid && bub_q != 16'hFFFF) bub_q <= bub_q + 16'd1;
    end
  end

  assign perf_fetched = fet_q;
  assign perf_bubbles = bub_q;
`else
  assign perf_fetched = 16'h0000;
  assign perf_bubbles = 16'h0000;
`endif

endmodule
